// File: rtl/mul_issue.sv
// M-extension multiply issue/writeback sequencer in front of an iterative multiplier.
// Optional result reuse cache enabled by defining MUL_FUSE_EN.
package mul_issue_pkg;
  typedef enum logic [1:0] {
    mul_ss = 2'd0,
    mul_su = 2'd1,
    mul_uu = 2'd2,
    mul_lo = 2'd3
  } mul_ops;
endpackage

module mul_issue
  import mul_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic [4:0]        req_rd,
  output logic              mul_start,
  output logic [XLEN-1:0]   mul_multiplicand,
  output logic [XLEN-1:0]   mul_multiplier,
  output mul_ops            mul_op,
  input  logic [2*XLEN-1:0] mul_result,
  input  logic              mul_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [1:0]      r_f3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_rsp_data;
  mul_ops          r_op;
  logic            w_accept;
  logic            w_done;
  logic            w_hit;
  logic [XLEN-1:0] w_hit_data;

  function automatic mul_ops f_op(input logic [1:0] f3);
    case (f3)
      2'b01:   f_op = mul_ss;
      2'b10:   f_op = mul_su;
      2'b11:   f_op = mul_uu;
      default: f_op = mul_lo;
    endcase
  endfunction

  // MUL writes back the low word, every MULH* variant the high word.
  function automatic logic [XLEN-1:0] f_sel(input logic [1:0] f3, input logic [2*XLEN-1:0] p);
    f_sel = (f3 == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign w_accept = req_valid && req_ready;
  assign w_done   = (r_state == WAIT) && mul_done;

`ifdef MUL_FUSE_EN
  logic            r_c_vld;
  logic [XLEN-1:0] r_c_rs1;
  logic [XLEN-1:0] r_c_rs2;
  logic [1:0]      r_c_f3;
  logic [2*XLEN-1:0] r_c_prod;

  // The low word is sign-agnostic, so MUL may reuse any cached product.
  assign w_hit = r_c_vld && !req_funct3[2] && (req_rs1 == r_c_rs1) && (req_rs2 == r_c_rs2) &&
                 ((req_funct3[1:0] == r_c_f3) || (req_funct3[1:0] == 2'b00));
  assign w_hit_data = f_sel(req_funct3[1:0], r_c_prod);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_c_vld <= 1'b0;
    end else if (w_done) begin
      r_c_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_done) begin
      r_c_rs1  <= r_rs1;
      r_c_rs2  <= r_rs2;
      r_c_f3   <= r_f3;
      r_c_prod <= mul_result;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next = (req_funct3[2] || w_hit) ? RESP : ISSUE;
        end
      end
      ISSUE:   w_next = WAIT;
      WAIT:    if (mul_done) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    mul_start = (r_state == ISSUE);
    rsp_valid = (r_state == RESP);
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_f3       <= 2'b00;
      r_rd       <= 5'd0;
      r_rsp_data <= '0;
      r_op       <= mul_lo;
    end else if (w_accept) begin
      r_rs1 <= req_rs1;
      r_rs2 <= req_rs2;
      r_f3  <= req_funct3[1:0];
      r_rd  <= req_rd;
      r_op  <= f_op(req_funct3[1:0]);
      if (req_funct3[2]) begin
        r_rsp_data <= '0;
      end else if (w_hit) begin
        r_rsp_data <= w_hit_data;
      end
    end else if (w_done) begin
      r_rsp_data <= f_sel(r_f3, mul_result);
    end
  end

  assign mul_multiplicand = r_rs1;
  assign mul_multiplier   = r_rs2;
  assign mul_op           = r_op;
  assign rsp_data         = r_rsp_data;
  assign rsp_rd           = r_rd;

endmodule

// File: doc/mul_issue.md
MUL_ISSUE -- requirements
Module: mul_issue

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-004 req_valid  input  1  EX-stage M-extension request valid.
REQ-005 req_ready  output  1  request accepted this cycle when req_valid && req_ready.
REQ-006 req_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx divide (not handled here).
REQ-007 req_rs1, req_rs2  input  32 each  source operands.
REQ-008 req_rd  input  5  destination register tag.
REQ-009 mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-010 mul_multiplicand, mul_multiplier  output  32 each  operands to the multiplier, driven from registers.
REQ-011 mul_op  output  mul_ops  one of mul_ss, mul_su, mul_uu, mul_lo.
REQ-012 mul_result  input  64  multiplier product; mul_done  input  1  product-valid strobe.
REQ-013 rsp_valid  output  1; rsp_ready  input  1; rsp_data  output  32; rsp_rd  output  5  writeback response.
REQ-014 busy  output  1  high whenever state != IDLE; drives the pipeline stall.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 On acceptance, the block latches rs1, rs2, funct3 and rd.
- funct3[2]=0 -> ISSUE.
- funct3[2]=1 -> RESP with rsp_data=0; no mul_start is issued.
REQ-018 ISSUE lasts exactly one cycle with mul_start=1, then moves to WAIT; mul_start is 0 in every other state.
REQ-019 mul_multiplicand=latched rs1, mul_multiplier=latched rs2, and mul_op SHALL stay constant from ISSUE until mul_done is sampled.
- MUL -> mul_lo; MULH -> mul_ss; MULHSU -> mul_su; MULHU -> mul_uu.
REQ-020 In WAIT, when mul_done=1 the block registers mul_result and moves to RESP the next cycle.
- rsp_data = result[31:0] for MUL, result[63:32] otherwise.
REQ-021 In RESP, rsp_valid=1 and rsp_data/rsp_rd are held stable until rsp_ready=1.
- On handshake -> IDLE; a new request can be accepted on the following cycle (no same-cycle back-to-back accept).
REQ-022 Latency from accept cycle t to first rsp_valid: t+37 with the standard 36-cycle multiplier (start -> 32 BUSY, SIGN_BIT, CLEANUP, DONE), i.e. 1 cycle after mul_done.
REQ-023 mul_done asserted outside WAIT SHALL be ignored.
REQ-024 rsp_ready held low in RESP: no state change, and outputs do not glitch.

Reset
REQ-025 With rst=0 at a rising edge:
- state=IDLE.
- rsp_valid=0, mul_start=0, busy=0, req_ready=1 from the next cycle.
- rsp_data=0, rsp_rd=0, latched operands=0, mul_op=mul_lo.
REQ-026 Reset mid-operation (ISSUE/WAIT/RESP) abandons the operation with no response; a later stale mul_done is ignored per REQ-023.

Configuration
REQ-027 Macro MUL_FUSE_EN.
- Defined: the block keeps a result cache {valid, rs1, rs2, funct3, 64-bit product}, written at each WAIT->RESP.
  - Hit condition: request operands equal the cached operands AND (request funct3 == cached funct3 OR request is MUL).
  - On a hit, acceptance goes directly to RESP the next cycle (latency 1) with no mul_start.
  - Cache valid is cleared on reset.
- Undefined: no cache; every multiply request goes through ISSUE/WAIT.

Verification
REQ-028 MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> one mul_start with mul_op=mul_uu; rsp_data=0xFFFFFFFE at t+37; rsp_rd echoed.
REQ-029 MUL rs1=0x00000007, rs2=0xFFFFFFFD -> rsp_data=0xFFFFFFEB; MULH with the same operands (fuse off) -> 0xFFFFFFFF.
REQ-030 rsp_ready held low 10 cycles in RESP -> rsp_valid and rsp_data stable; req_ready=0 and busy=1 throughout.
REQ-031 rst=0 asserted in WAIT cycle 20 -> next cycle IDLE with rsp_valid=0; the stale mul_done produces no response.
REQ-032 funct3=100 -> no mul_start; rsp_data=0 with rsp_valid at t+1.
REQ-033 MUL_FUSE_EN defined: MULH a,b then MUL a,b -> second response 1 cycle after accept with no mul_start; MULHU a,b after MULH a,b -> full 37-cycle path.
